// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control unit handshake/control bundle
interface multicycle_control_unit_if #(
    parameter int CNT_W = 64
);
    logic [31:0]      instr;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_write;
    logic             dmem_req;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             word_op;
    logic             pc_write;
    logic             pc_sel;
    logic             retire;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;

    // Controller side
    modport master (
        input  instr, zero, imem_ready, dmem_ready,
        output imem_req, ir_write, dmem_req, mem_read, mem_write, reg_write,
               mem_to_reg, alu_src, alu_op, word_op, pc_write, pc_sel,
               retire, trap, trap_cause, state, instret
    );

    // Datapath / memory side
    modport slave (
        output instr, zero, imem_ready, dmem_ready,
        input  imem_req, ir_write, dmem_req, mem_read, mem_write, reg_write,
               mem_to_reg, alu_src, alu_op, word_op, pc_write, pc_sel,
               retire, trap, trap_cause, state, instret
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV64 control FSM with memory timeout and instret
module multicycle_control_unit #(
    parameter bit ENABLE_W    = 1'b1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_unit_if.master   bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // C_ILL is encoding 0 so a reset class reads as "nothing decoded"
    typedef enum logic [2:0] {
        C_ILL = 3'd0,
        C_R   = 3'd1,
        C_I   = 3'd2,
        C_LD  = 3'd3,
        C_ST  = 3'd4,
        C_BR  = 3'd5,
        C_RW  = 3'd6,
        C_IW  = 3'd7
    } cls_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t             state_q, state_d;
    cls_t               cls_q, cls_d, dec_cls;
    logic               bne_q, bne_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               trap_q, trap_d;
    logic [1:0]         cause_q, cause_d;
    logic               timeout_hit;

    logic       imem_req, ir_write, dmem_req, mem_read, mem_write;
    logic       reg_write, mem_to_reg, alu_src, word_op;
    logic       pc_write, pc_sel, retire;
    logic [1:0] alu_op;

    // Classify the opcode held in the instruction register
    always_comb begin
        dec_cls = C_ILL;
        case (bus.instr[6:0])
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LD;
            7'b0100011: dec_cls = C_ST;
            7'b1100011: dec_cls = (bus.instr[14:13] == 2'b00) ? C_BR : C_ILL;
            7'b0111011: dec_cls = ENABLE_W ? C_RW : C_ILL;
            7'b0011011: dec_cls = ENABLE_W ? C_IW : C_ILL;
            default:    dec_cls = C_ILL;
        endcase
    end

    // Timeout fires only on the last permitted wait cycle; a ready in that cycle still wins
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

    // Next-state and control outputs
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        bne_d      = bne_q;
        wait_d     = wait_q;
        trap_d     = trap_q;
        cause_d    = cause_q;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        dmem_req   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        word_op    = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                bne_d = bus.instr[12];
                if (dec_cls == C_ILL) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b01;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    C_RW: begin
                        alu_op  = 2'b10;
                        word_op = 1'b1;
                        state_d = S_WB;
                    end
                    C_I: begin
                        alu_src = 1'b1;
                        alu_op  = 2'b11;
                        state_d = S_WB;
                    end
                    C_IW: begin
                        alu_src = 1'b1;
                        alu_op  = 2'b11;
                        word_op = 1'b1;
                        state_d = S_WB;
                    end
                    C_LD, C_ST: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                        wait_d  = '0;
                    end
                    C_BR: begin
                        alu_op   = 2'b01;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        pc_sel   = bne_q ? ~bus.zero : bus.zero;
                        state_d  = S_FETCH;
                        wait_d   = '0;
                    end
                    default: begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = (cls_q == C_LD);
                mem_write = (cls_q == C_ST);
                if (bus.dmem_ready) begin
                    if (cls_q == C_LD) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                        wait_d   = '0;
                    end
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b11;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == C_LD);
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
                wait_d     = '0;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
                wait_d  = '0;
            end
        endcase
    end

    assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cls_q     <= C_ILL;
            bne_q     <= 1'b0;
            wait_q    <= '0;
            instret_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            bne_q     <= bne_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

    assign bus.imem_req   = imem_req;
    assign bus.ir_write   = ir_write;
    assign bus.dmem_req   = dmem_req;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.reg_write  = reg_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src    = alu_src;
    assign bus.alu_op     = alu_op;
    assign bus.word_op    = word_op;
    assign bus.pc_write   = pc_write;
    assign bus.pc_sel     = pc_sel;
    assign bus.retire     = retire;
    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;
    assign bus.state      = state_q;
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.CNT_W(64)) ifa ();
    multicycle_control_unit_if #(.CNT_W(4))  ifb ();

    assign ifa.instr = instr;
    assign ifa.zero = zero;
    assign ifa.imem_ready = imem_ready;
    assign ifa.dmem_ready = dmem_ready;
    assign ifb.instr = instr;
    assign ifb.zero = zero;
    assign ifb.imem_ready = imem_ready;
    assign ifb.dmem_ready = dmem_ready;

    multicycle_control_unit #(.ENABLE_W(1'b1), .MEM_TIMEOUT(16), .CNT_W(64)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    multicycle_control_unit #(.ENABLE_W(1'b0), .MEM_TIMEOUT(4), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));

    logic [13:0] ctl_a, ctl_b, o_ctl;
    logic [2:0]  o_state;
    logic [1:0]  o_cause;
    logic        o_trap;
    logic [63:0] o_instret;

    assign ctl_a = {ifa.imem_req, ifa.ir_write, ifa.dmem_req, ifa.mem_read, ifa.mem_write,
                    ifa.reg_write, ifa.mem_to_reg, ifa.alu_src, ifa.alu_op, ifa.word_op,
                    ifa.pc_write, ifa.pc_sel, ifa.retire};
    assign ctl_b = {ifb.imem_req, ifb.ir_write, ifb.dmem_req, ifb.mem_read, ifb.mem_write,
                    ifb.reg_write, ifb.mem_to_reg, ifb.alu_src, ifb.alu_op, ifb.word_op,
                    ifb.pc_write, ifb.pc_sel, ifb.retire};
    assign o_ctl     = sel ? ctl_b : ctl_a;
    assign o_state   = sel ? ifb.state : ifa.state;
    assign o_cause   = sel ? ifb.trap_cause : ifa.trap_cause;
    assign o_trap    = sel ? ifb.trap : ifa.trap;
    assign o_instret = sel ? {60'd0, ifb.instret} : ifa.instret;

    typedef struct {
        int          lat;
        logic        pc_sel;
        logic        pc_write;
        int          n_retire;
        int          n_rw;
        int          n_rw_bad;
        int          n_req;
        int          n_rd;
        int          n_wr;
        int          n_m2r;
        int          n_fetch;
        int          n_trap;
        int          n_trap_ctl;
        logic [1:0]  alu_op;
        logic        alu_src;
        logic        word_op;
        logic [23:0] trace;
        logic [63:0] instret;
    } obs_t;

    typedef struct {
        int          lat;
        logic        pc_sel;
        logic [63:0] instret;
    } exp_t;

    exp_t exp_q[$];

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one instruction for at most 40 cycles, ready inputs released after the given delays
    task automatic drive_instr(input logic [31:0] ins, input logic z, input int imem_dly,
                               input int dmem_dly, output obs_t o);
        int fcnt;
        int mcnt;
        o = '{default: 0};
        fcnt = 0;
        mcnt = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            instr = ins;
            zero = z;
            imem_ready = (o_state == 3'd0) && (fcnt >= imem_dly);
            dmem_ready = (o_state == 3'd3) && (mcnt >= dmem_dly);
            #1;
            o.trace = {o.trace[20:0], o_state};
            if (o_state == 3'd0) begin fcnt++; o.n_fetch++; end
            if (o_state == 3'd3) mcnt++;
            if (o_state == 3'd5) begin
                o.n_trap++;
                if (o_ctl != 14'd0) o.n_trap_ctl++;
            end
            if (o_ctl[8]) begin
                o.n_rw++;
                if (o_state != 3'd4) o.n_rw_bad++;
            end
            if (o_ctl[11]) o.n_req++;
            if (o_ctl[10]) o.n_rd++;
            if (o_ctl[9])  o.n_wr++;
            if (o_ctl[7])  o.n_m2r++;
            if (o_state == 3'd2) begin
                o.alu_op  = o_ctl[5:4];
                o.alu_src = o_ctl[6];
                o.word_op = o_ctl[3];
            end
            if (o_ctl[0]) begin
                o.n_retire++;
                o.lat = cyc;
                o.pc_sel = o_ctl[1];
                o.pc_write = o_ctl[2];
            end
            @(negedge clk);
            if (o.n_retire != 0) begin
                o.instret = o_instret;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        #1;
        checks++;
        if (o_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        checks++;
        if (o_ctl !== 14'h2000) begin failures++; $display("FAIL reset_ctl got=%h exp=2000", o_ctl); end
        checks++;
        if (o_instret !== 64'd0 || o_trap !== 1'b0 || o_cause !== 2'b00) begin
            failures++; $display("FAIL reset_regs instret=%0d trap=%b cause=%b exp 0/0/00", o_instret, o_trap, o_cause);
        end
    endtask

    task automatic test_r_type();
        obs_t o;
        exp_t e;
        sel = 1'b0;
        do_reset();
        exp_q.push_back('{lat: 4, pc_sel: 1'b0, instret: 64'd1});
        drive_instr(32'h003100B3, 1'b0, 0, 0, o);
        e = exp_q.pop_front();
        checks++;
        if (o.lat !== e.lat || o.instret !== e.instret) begin
            failures++; $display("FAIL add_retire lat=%0d instret=%0d exp %0d/%0d", o.lat, o.instret, e.lat, e.instret);
        end
        checks++;
        if (o.trace !== 24'h000054 || o_state !== 3'd0) begin
            failures++; $display("FAIL add_states trace=%h end=%0d exp 000054/0", o.trace, o_state);
        end
        checks++;
        if (o.alu_op !== 2'b10 || o.alu_src !== 1'b0 || o.word_op !== 1'b0) begin
            failures++; $display("FAIL add_exec op=%b src=%b w=%b exp 10/0/0", o.alu_op, o.alu_src, o.word_op);
        end
        checks++;
        if (o.n_rw !== 1 || o.n_rw_bad !== 0 || o.n_retire !== 1) begin
            failures++; $display("FAIL add_regwrite rw=%0d bad=%0d ret=%0d exp 1/0/1", o.n_rw, o.n_rw_bad, o.n_retire);
        end
    endtask

    task automatic test_word_op();
        obs_t o;
        exp_t e;
        sel = 1'b0;
        do_reset();
        exp_q.push_back('{lat: 4, pc_sel: 1'b0, instret: 64'd1});
        drive_instr(32'h003100BB, 1'b0, 0, 0, o);
        e = exp_q.pop_front();
        checks++;
        if (o.lat !== e.lat || o.instret !== e.instret || o.alu_op !== 2'b10 || o.word_op !== 1'b1 || o.alu_src !== 1'b0) begin
            failures++; $display("FAIL addw lat=%0d instret=%0d op=%b w=%b src=%b exp %0d/%0d/10/1/0",
                                 o.lat, o.instret, o.alu_op, o.word_op, o.alu_src, e.lat, e.instret);
        end
        exp_q.push_back('{lat: 4, pc_sel: 1'b0, instret: 64'd2});
        drive_instr(32'h0010809B, 1'b0, 0, 0, o);
        e = exp_q.pop_front();
        checks++;
        if (o.lat !== e.lat || o.instret !== e.instret || o.alu_op !== 2'b11 || o.word_op !== 1'b1 || o.alu_src !== 1'b1) begin
            failures++; $display("FAIL addiw lat=%0d instret=%0d op=%b w=%b src=%b exp %0d/%0d/11/1/1",
                                 o.lat, o.instret, o.alu_op, o.word_op, o.alu_src, e.lat, e.instret);
        end
    endtask

    task automatic test_load_store();
        obs_t o;
        exp_t e;
        sel = 1'b0;
        do_reset();
        exp_q.push_back('{lat: 8, pc_sel: 1'b0, instret: 64'd1});
        drive_instr(32'h0000B083, 1'b0, 0, 3, o);
        e = exp_q.pop_front();
        checks++;
        if (o.lat !== e.lat || o.instret !== e.instret) begin
            failures++; $display("FAIL ld_retire lat=%0d instret=%0d exp %0d/%0d", o.lat, o.instret, e.lat, e.instret);
        end
        checks++;
        if (o.n_req !== 4 || o.n_rd !== 4 || o.n_wr !== 0 || o.n_m2r !== 1 || o.n_rw !== 1) begin
            failures++; $display("FAIL ld_mem req=%0d rd=%0d wr=%0d m2r=%0d rw=%0d exp 4/4/0/1/1",
                                 o.n_req, o.n_rd, o.n_wr, o.n_m2r, o.n_rw);
        end
        checks++;
        if (o.trace !== 24'h0536DC || o.alu_op !== 2'b00 || o.alu_src !== 1'b1) begin
            failures++; $display("FAIL ld_path trace=%h op=%b src=%b exp 0536dc/00/1", o.trace, o.alu_op, o.alu_src);
        end
        exp_q.push_back('{lat: 4, pc_sel: 1'b0, instret: 64'd2});
        drive_instr(32'h0010B023, 1'b1, 0, 0, o);
        e = exp_q.pop_front();
        checks++;
        if (o.lat !== e.lat || o.instret !== e.instret || o.pc_sel !== e.pc_sel || o.pc_write !== 1'b1) begin
            failures++; $display("FAIL sd_retire lat=%0d instret=%0d psel=%b pw=%b exp %0d/%0d/%b/1",
                                 o.lat, o.instret, o.pc_sel, o.pc_write, e.lat, e.instret, e.pc_sel);
        end
        checks++;
        if (o.n_wr !== 1 || o.n_rd !== 0 || o.n_rw !== 0) begin
            failures++; $display("FAIL sd_mem wr=%0d rd=%0d rw=%0d exp 1/0/0", o.n_wr, o.n_rd, o.n_rw);
        end
    endtask

    task automatic test_branch();
        obs_t o;
        exp_t e;
        logic [31:0] br [3]  = '{32'h00208063, 32'h00209063, 32'h00208063};
        logic        zr [3]  = '{1'b1, 1'b1, 1'b0};
        logic        tk [3]  = '{1'b1, 1'b0, 1'b0};
        sel = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{lat: 3, pc_sel: tk[k], instret: 64'(k + 1)});
            drive_instr(br[k], zr[k], 0, 0, o);
            e = exp_q.pop_front();
            checks++;
            if (o.lat !== e.lat || o.pc_sel !== e.pc_sel || o.instret !== e.instret) begin
                failures++; $display("FAIL branch%0d lat=%0d psel=%b instret=%0d exp %0d/%b/%0d",
                                     k, o.lat, o.pc_sel, o.instret, e.lat, e.pc_sel, e.instret);
            end
            checks++;
            if (o.pc_write !== 1'b1 || o.alu_op !== 2'b01 || o.trace[8:0] !== 9'o012 || o.n_rw !== 0) begin
                failures++; $display("FAIL branch%0d_ctl pw=%b op=%b trace=%h rw=%0d exp 1/01/00a/0",
                                     k, o.pc_write, o.alu_op, o.trace, o.n_rw);
            end
        end
    endtask

    task automatic test_fetch_wait();
        obs_t o;
        exp_t e;
        sel = 1'b0;
        do_reset();
        exp_q.push_back('{lat: 6, pc_sel: 1'b0, instret: 64'd1});
        drive_instr(32'h003100B3, 1'b0, 2, 0, o);
        e = exp_q.pop_front();
        checks++;
        if (o.lat !== e.lat || o.n_fetch !== 3 || o.instret !== e.instret) begin
            failures++; $display("FAIL fetch_wait lat=%0d fetch=%0d instret=%0d exp %0d/3/%0d",
                                 o.lat, o.n_fetch, o.instret, e.lat, e.instret);
        end
    endtask

    task automatic test_illegal();
        obs_t o;
        logic [31:0] bad [2] = '{32'h00000000, 32'h0020A063};
        sel = 1'b0;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            drive_instr(bad[k], 1'b0, 0, 0, o);
            checks++;
            if (o_state !== 3'd5 || o_cause !== 2'b01 || o_trap !== 1'b1 || o.n_retire !== 0) begin
                failures++; $display("FAIL illegal%0d state=%0d cause=%b trap=%b ret=%0d exp 5/01/1/0",
                                     k, o_state, o_cause, o_trap, o.n_retire);
            end
        end
        sel = 1'b1;
        do_reset();
        drive_instr(32'h003100BB, 1'b0, 0, 0, o);
        checks++;
        if (o.n_fetch !== 1 || o.n_trap !== 38 || o.n_trap_ctl !== 0 || o_cause !== 2'b01 || o_trap !== 1'b1) begin
            failures++; $display("FAIL w_disabled fetch=%0d trapcyc=%0d trapctl=%0d cause=%b trap=%b exp 1/38/0/01/1",
                                 o.n_fetch, o.n_trap, o.n_trap_ctl, o_cause, o_trap);
        end
        do_reset();
        #1;
        checks++;
        if (o_state !== 3'd0 || o_trap !== 1'b0 || o_cause !== 2'b00) begin
            failures++; $display("FAIL trap_reset state=%0d trap=%b cause=%b exp 0/0/00", o_state, o_trap, o_cause);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        sel = 1'b1;
        do_reset();
        drive_instr(32'h003100B3, 1'b0, 100, 0, o);
        checks++;
        if (o.n_fetch !== 4 || o.n_trap !== 36 || o_cause !== 2'b10 || o_state !== 3'd5) begin
            failures++; $display("FAIL imem_timeout fetch=%0d trapcyc=%0d cause=%b state=%0d exp 4/36/10/5",
                                 o.n_fetch, o.n_trap, o_cause, o_state);
        end
        do_reset();
        exp_q.push_back('{lat: 7, pc_sel: 1'b0, instret: 64'd1});
        drive_instr(32'h003100B3, 1'b0, 3, 0, o);
        e = exp_q.pop_front();
        checks++;
        if (o.lat !== e.lat || o.instret !== e.instret || o.n_trap !== 0 || o_trap !== 1'b0) begin
            failures++; $display("FAIL imem_last_cycle lat=%0d instret=%0d trapcyc=%0d trap=%b exp %0d/%0d/0/0",
                                 o.lat, o.instret, o.n_trap, o_trap, e.lat, e.instret);
        end
        do_reset();
        drive_instr(32'h0000B083, 1'b0, 0, 100, o);
        checks++;
        if (o.n_req !== 4 || o_cause !== 2'b11 || o_state !== 3'd5 || o.n_trap_ctl !== 0) begin
            failures++; $display("FAIL dmem_timeout req=%0d cause=%b state=%0d trapctl=%0d exp 4/11/5/0",
                                 o.n_req, o_cause, o_state, o.n_trap_ctl);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        int   n;
        sel = 1'b1;
        do_reset();
        for (int k = 0; k < 17; k++) begin
            exp_q.push_back('{lat: 4, pc_sel: 1'b0, instret: 64'((k + 1) % 16)});
            drive_instr(32'h00108093, 1'b0, 0, 0, o);
            e = exp_q.pop_front();
            checks++;
            if (o.lat !== e.lat || o.instret !== e.instret) begin
                failures++; $display("FAIL b2b%0d lat=%0d instret=%0d exp %0d/%0d", k, o.lat, o.instret, e.lat, e.instret);
            end
        end
        // store stalls in MEM, then reset lands mid-access
        instr = 32'h0010B023;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        n = 0;
        while (o_state != 3'd3 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (o_state !== 3'd3 || o_ctl[9] !== 1'b1 || o_instret !== 64'd1) begin
            failures++; $display("FAIL st_stall state=%0d wr=%b instret=%0d exp 3/1/1", o_state, o_ctl[9], o_instret);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (o_state !== 3'd0 || o_ctl[9] !== 1'b0 || o_ctl[11] !== 1'b0 || o_instret !== 64'd0 || o_trap !== 1'b0) begin
            failures++; $display("FAIL mid_mem_reset state=%0d wr=%b req=%b instret=%0d trap=%b exp 0/0/0/0/0",
                                 o_state, o_ctl[9], o_ctl[11], o_instret, o_trap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_r_type();
        test_word_op();
        test_load_store();
        test_branch();
        test_fetch_wait();
        test_illegal();
        test_timeout();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
